// File: rtl/sync_mux_rr_pkg.sv
// Shared definitions for the sync_mux_rr block: mode encodings and the
// select-width helper used by the interface, the arbiter and the top.
package sync_mux_rr_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Width of a channel index: ceil(log2(n)), never less than one bit.
  function automatic int sel_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_mux_rr_if.sv
// Bus bundle for sync_mux_rr: per-channel input handshake, select/mode
// controls and the registered output handshake.
interface sync_mux_rr_if
  import sync_mux_rr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = sel_w(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/sync_mux_rr_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel after ptr,
// wrapping around, with ptr itself searched last.
module rr_arbiter
  import sync_mux_rr_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]          req,
  input  logic [sel_w(NCH)-1:0]   ptr,
  output logic [NCH-1:0]          gnt,
  output logic [sel_w(NCH)-1:0]   gnt_idx
);
  localparam int SELW = sel_w(NCH);

  logic found;
  int   idx;

  // Rotating priority search starting one past the last winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NCH; off++) begin
      idx = (int'(ptr) + off) % NCH;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/sync_mux_rr.sv
// sync_mux_rr: N-channel to one registered mux with fixed-select or
// round-robin arbitration and a single output register stage.
// Optional feature: define SYNC_MUX_RR_XFER_CNT_EN to add the 16-bit
// xfer_cnt output counting accepted input transfers.
module sync_mux_rr
  import sync_mux_rr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  sync_mux_rr_if.slave bus
`ifdef SYNC_MUX_RR_XFER_CNT_EN
  ,
  output logic [15:0]  xfer_cnt
`endif
);
  localparam int SELW = sel_w(NCH);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q,   out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q,      ptr_d;

  logic             can_accept;
  logic             rr_mode;
  logic [NCH-1:0]   rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic [NCH-1:0]   gnt_oh;
  logic [SELW-1:0]  gnt_idx;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  // The register can take a new word when empty or when it drains this cycle.
  assign can_accept = ~out_valid_q | bus.out_ready;
  assign rr_mode    = (bus.mode == MODE_RR);

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Grant selection; fixed mode grants sel regardless of its valid, out-of-range sel grants nothing.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    if (!rst && can_accept) begin
      if (rr_mode) begin
        gnt_oh  = rr_gnt;
        gnt_idx = rr_idx;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          gnt_oh[k] = (int'(bus.sel) == k);
        end
        gnt_idx = bus.sel;
      end
    end
  end

  assign bus.in_ready = gnt_oh;
  assign xfer         = |(gnt_oh & bus.in_valid);

  // Data mux driven by the one-hot grant.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_oh[k]) mux_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register and pointer next-state: load on transfer, empty on drain, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = mux_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (rr_mode) ptr_d = gnt_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset leaves ptr on the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

`ifdef SYNC_MUX_RR_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Free-running transfer counter, wraps naturally at 16 bits.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (xfer) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
